// File: rtl/coffee_machine_ctrl_pkg.sv
// Shared definitions for the coffee-machine controller: state encoding and
// width helpers for the brew timer and the brew counter.
package coffee_machine_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_HEAT    = 3'd1,
        ST_READY   = 3'd2,
        ST_BREW    = 3'd3,
        ST_DESCALE = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // Wide enough to hold the longest brew (largest size) without truncation.
    function automatic int brew_timer_width(input int base_cycles, input int size_w);
        return $clog2(base_cycles * (2 ** size_w) + 1);
    endfunction

    function automatic int count_width(input int interval);
        return $clog2(interval + 1);
    endfunction

    function automatic int heat_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/coffee_machine_ctrl_if.sv
// Front-panel / sensor side of the coffee-machine controller: synchronised
// inputs from the panel and Moore status outputs towards the drivers.
interface coffee_machine_ctrl_if #(
    parameter int SIZE_W = 2,
    parameter int CW     = 3
);
    logic              water_ok;
    logic              temp_ok;
    logic              brew_req;
    logic              stop;
    logic [SIZE_W-1:0] size;
    logic              descale_done;
    logic              fault_clear;

    logic              waiting;
    logic              heater;
    logic              ready;
    logic              brewing;
    logic              descale_req;
    logic              fault;
    logic [CW-1:0]     brew_count;

    modport master (
        output water_ok, temp_ok, brew_req, stop, size, descale_done, fault_clear,
        input  waiting, heater, ready, brewing, descale_req, fault, brew_count
    );

    modport slave (
        input  water_ok, temp_ok, brew_req, stop, size, descale_done, fault_clear,
        output waiting, heater, ready, brewing, descale_req, fault, brew_count
    );
endinterface

// File: rtl/coffee_machine_ctrl_timer.sv
// Loadable down-counter with zero flag; holds the remaining brew cycles.
module coffee_machine_ctrl_timer #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/coffee_machine_ctrl.sv
// Coffee-machine controller: warm-up, timed brew by cup size, heat-timeout and
// dry-run fault handling, and descale lock-out after a fixed number of brews.
module coffee_machine_ctrl
    import coffee_machine_ctrl_pkg::*;
#(
    parameter int BASE_BREW_CYCLES = 8,
    parameter int SIZE_W           = 2,
    parameter int HEAT_TIMEOUT     = 32,
    parameter int DESCALE_INTERVAL = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    coffee_machine_ctrl_if.slave  bus
);
    localparam int TW = brew_timer_width(BASE_BREW_CYCLES, SIZE_W);
    localparam int CW = count_width(DESCALE_INTERVAL);
    localparam int HW = heat_width(HEAT_TIMEOUT);

    localparam logic [TW-1:0] BASE_T      = TW'(BASE_BREW_CYCLES);
    localparam logic [HW-1:0] HEAT_LAST   = HW'(HEAT_TIMEOUT - 1);
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(DESCALE_INTERVAL);

    state_t        state_q, state_d;
    logic [HW-1:0] heat_q, heat_d;
    logic [CW-1:0] count_q, count_d;

    logic          brew_load;
    logic          brew_dec;
    logic [TW-1:0] brew_len;
    logic [TW-1:0] brew_timer;
    logic          brew_zero;
    logic          brew_last;

    // The loaded brew length is the latched cup size; computed at full timer width.
    assign brew_len  = BASE_T * (TW'(bus.size) + TW'(1));
    assign brew_last = (brew_timer == TW'(1)) || brew_zero;

    coffee_machine_ctrl_timer #(.W(TW)) u_brew_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (brew_load),
        .load_val (brew_len),
        .dec      (brew_dec),
        .count    (brew_timer),
        .zero     (brew_zero)
    );

    always_comb begin
        state_d   = state_q;
        heat_d    = '0;
        count_d   = count_q;
        brew_load = 1'b0;
        brew_dec  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (bus.water_ok) state_d = ST_HEAT;
            end
            ST_HEAT: begin
                if (!bus.water_ok)           state_d = ST_WAIT;
                else if (bus.temp_ok)        state_d = ST_READY;
                else if (heat_q == HEAT_LAST) state_d = ST_FAULT;
                else                         heat_d  = heat_q + HW'(1);
            end
            ST_READY: begin
                if (!bus.water_ok) begin
                    state_d = ST_WAIT;
                end else if (!bus.temp_ok) begin
                    state_d = ST_HEAT;
                end else if (bus.brew_req) begin
                    state_d   = ST_BREW;
                    brew_load = 1'b1;
                end
            end
            ST_BREW: begin
                // Dry run outranks stop, and stop outranks a completing brew.
                if (!bus.water_ok) begin
                    state_d = ST_FAULT;
                end else if (bus.stop) begin
                    state_d = ST_READY;
                end else if (brew_last) begin
                    count_d = count_q + CW'(1);
                    state_d = (count_d == COUNT_LIMIT) ? ST_DESCALE : ST_READY;
                end else begin
                    brew_dec = 1'b1;
                end
            end
            ST_DESCALE: begin
                if (bus.descale_done) begin
                    state_d = ST_WAIT;
                    count_d = '0;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clear) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            heat_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            heat_q  <= heat_d;
            count_q <= count_d;
        end
    end

    assign bus.waiting     = (state_q == ST_WAIT);
    assign bus.heater      = (state_q == ST_HEAT);
    assign bus.ready       = (state_q == ST_READY);
    assign bus.brewing     = (state_q == ST_BREW);
    assign bus.descale_req = (state_q == ST_DESCALE);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.brew_count  = count_q;
endmodule
